// File: rtl/edge_req_gen_pkg.sv
//------------------------------------------------------------------------------
// Module   : edge_req_gen_pkg
// Brief    : Shared line/slot geometry and FSM state type for the edge stages.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package edge_req_gen_pkg;

   localparam int EDGE_BYTES      = 4;
   localparam int LINE_BYTES      = 64;
   localparam int EDGES_PER_LINE  = LINE_BYTES / EDGE_BYTES;
   localparam int EDGE_SLOT_WIDTH = $clog2(EDGES_PER_LINE);
   localparam int LINE_SHIFT      = $clog2(LINE_BYTES);

   localparam logic [EDGE_SLOT_WIDTH-1:0] SLOT_MAX = '1;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_t;

endpackage

`default_nettype wire

// File: rtl/edge_req_gen_if.sv
//------------------------------------------------------------------------------
// Module   : edge_req_gen_if
// Brief    : Edge-list read request channel (valid/ready) towards HBM.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface edge_req_gen_if
   import edge_req_gen_pkg::*;
#(
   parameter int V_ID_WIDTH = 16,
   parameter int HBM_AWIDTH = 32
);
   logic [HBM_AWIDTH-1:0]      edge_rd_addr;
   logic [V_ID_WIDTH-1:0]      edge_rd_v_id;
   logic [EDGE_SLOT_WIDTH-1:0] edge_rd_lo;
   logic [EDGE_SLOT_WIDTH-1:0] edge_rd_hi;
   logic                       edge_rd_last;
   logic                       edge_rd_valid;
   logic                       edge_rd_ready;

   modport master (
      output edge_rd_addr, edge_rd_v_id, edge_rd_lo, edge_rd_hi,
             edge_rd_last, edge_rd_valid,
      input  edge_rd_ready
   );

   modport slave (
      input  edge_rd_addr, edge_rd_v_id, edge_rd_lo, edge_rd_hi,
             edge_rd_last, edge_rd_valid,
      output edge_rd_ready
   );
endinterface

`default_nettype wire

// File: rtl/edge_req_gen_fifo.sv
//------------------------------------------------------------------------------
// Module   : edge_req_fifo
// Brief    : Synchronous register-array FIFO with occupancy count.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module edge_req_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  wire                          clk,
   input  wire                          rst,
   input  wire                          i_push,
   input  wire  [WIDTH-1:0]             i_din,
   input  wire                          i_pop,
   output logic [WIDTH-1:0]             o_dout,
   output logic                         o_empty,
   output logic                         o_full,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CW'(DEPTH));
   assign o_count   = r_count;
   assign o_dout    = r_mem[r_rptr];
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wptr] <= i_din;
      end
   end

   // Pointers wrap explicitly so non-power-of-two depths stay correct.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) begin
            r_wptr <= (r_wptr == AW'(DEPTH-1)) ? '0 : r_wptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rptr <= (r_rptr == AW'(DEPTH-1)) ? '0 : r_rptr + AW'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/edge_req_gen.sv
//------------------------------------------------------------------------------
// Module   : edge_req_gen
// Brief    : Expands vertex edge-offset ranges into line-aligned HBM reads.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module edge_req_gen
   import edge_req_gen_pkg::*;
#(
   parameter int V_ID_WIDTH   = 16,
   parameter int V_OFF_DWIDTH = 32,
   parameter int HBM_AWIDTH   = 32,
   parameter int URAM_DELAY   = 3,
   parameter int FIFO_DEPTH   = 16
) (
   input  wire                     clk,
   input  wire                     rst,
   input  wire  [V_ID_WIDTH-1:0]   front_active_v_id,
   input  wire                     front_active_v_valid,
   input  wire  [V_OFF_DWIDTH-1:0] uram_loffset,
   input  wire  [V_OFF_DWIDTH-1:0] uram_roffset,
   input  wire                     uram_dvalid,
   input  wire  [HBM_AWIDTH-1:0]   edge_base_addr,
   output logic                    front_stall,
   output logic                    err_sticky,
   edge_req_gen_if.master          rd
);
   localparam int ENTRY_W  = V_ID_WIDTH + 2 * V_OFF_DWIDTH;
   localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
   localparam int LINE_W   = V_OFF_DWIDTH - EDGE_SLOT_WIDTH;
   localparam int STALL_TH = FIFO_DEPTH - URAM_DELAY - 1;

   logic [V_ID_WIDTH-1:0]      r_id_dly [URAM_DELAY];
   logic                       r_stall;
   logic                       r_err;

   logic                       w_push_req;
   logic                       w_push;
   logic                       w_pop;
   logic [ENTRY_W-1:0]         w_fifo_dout;
   logic                       w_empty;
   logic                       w_full;
   logic [CNT_W-1:0]           w_count;

   logic [V_ID_WIDTH-1:0]      w_head_id;
   logic [V_OFF_DWIDTH-1:0]    w_head_lo;
   logic [V_OFF_DWIDTH-1:0]    w_head_ro;
   logic [V_OFF_DWIDTH-1:0]    w_head_last_edge;
   logic [LINE_W-1:0]          w_head_line;
   logic [LINE_W-1:0]          w_head_end;
   logic [HBM_AWIDTH-1:0]      w_head_addr;
   logic [LINE_W-1:0]          w_adv_line;
   logic [HBM_AWIDTH-1:0]      w_adv_addr;

   state_t                     r_state,    w_state_nxt;
   logic [LINE_W-1:0]          r_cur_line, w_cur_line_nxt;
   logic [LINE_W-1:0]          r_end_line, w_end_line_nxt;
   logic [EDGE_SLOT_WIDTH-1:0] r_hi_slot,  w_hi_slot_nxt;
   logic [HBM_AWIDTH-1:0]      r_addr,     w_addr_nxt;
   logic [V_ID_WIDTH-1:0]      r_vid,      w_vid_nxt;
   logic [EDGE_SLOT_WIDTH-1:0] r_lo,       w_lo_nxt;
   logic [EDGE_SLOT_WIDTH-1:0] r_hi,       w_hi_nxt;
   logic                       r_last,     w_last_nxt;
   logic                       r_valid,    w_valid_nxt;
   logic                       w_load;

   // The vertex id is delayed to line up with the URAM read data.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < URAM_DELAY; i++) begin
            r_id_dly[i] <= '0;
         end
      end else begin
         r_id_dly[0] <= front_active_v_valid ? front_active_v_id : '0;
         for (int i = 1; i < URAM_DELAY; i++) begin
            r_id_dly[i] <= r_id_dly[i-1];
         end
      end
   end

   assign w_push_req = uram_dvalid & (uram_roffset > uram_loffset);
   assign w_push     = w_push_req & ~w_full;

   edge_req_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_din   ({r_id_dly[URAM_DELAY-1], uram_loffset, uram_roffset}),
      .i_pop   (w_pop),
      .o_dout  (w_fifo_dout),
      .o_empty (w_empty),
      .o_full  (w_full),
      .o_count (w_count)
   );

   // Stall threshold leaves room for every URAM read still in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_stall <= (w_count >= CNT_W'(STALL_TH));
         if ((uram_dvalid && (uram_roffset < uram_loffset)) || (w_push_req && w_full)) begin
            r_err <= 1'b1;
         end
      end
   end

   assign {w_head_id, w_head_lo, w_head_ro} = w_fifo_dout;
   assign w_head_last_edge = w_head_ro - V_OFF_DWIDTH'(1);
   assign w_head_line      = w_head_lo[V_OFF_DWIDTH-1:EDGE_SLOT_WIDTH];
   assign w_head_end       = w_head_last_edge[V_OFF_DWIDTH-1:EDGE_SLOT_WIDTH];
   assign w_head_addr      = edge_base_addr + (HBM_AWIDTH'(w_head_line) << LINE_SHIFT);
   assign w_adv_line       = r_cur_line + LINE_W'(1);
   assign w_adv_addr       = edge_base_addr + (HBM_AWIDTH'(w_adv_line) << LINE_SHIFT);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_cur_line <= '0;
         r_end_line <= '0;
         r_hi_slot  <= '0;
         r_addr     <= '0;
         r_vid      <= '0;
         r_lo       <= '0;
         r_hi       <= '0;
         r_last     <= 1'b0;
         r_valid    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cur_line <= w_cur_line_nxt;
         r_end_line <= w_end_line_nxt;
         r_hi_slot  <= w_hi_slot_nxt;
         r_addr     <= w_addr_nxt;
         r_vid      <= w_vid_nxt;
         r_lo       <= w_lo_nxt;
         r_hi       <= w_hi_nxt;
         r_last     <= w_last_nxt;
         r_valid    <= w_valid_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cur_line_nxt = r_cur_line;
      w_end_line_nxt = r_end_line;
      w_hi_slot_nxt  = r_hi_slot;
      w_addr_nxt     = r_addr;
      w_vid_nxt      = r_vid;
      w_lo_nxt       = r_lo;
      w_hi_nxt       = r_hi;
      w_last_nxt     = r_last;
      w_valid_nxt    = r_valid;
      w_load         = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_load = ~w_empty;
         end
         ST_ISSUE: begin
            if (rd.edge_rd_ready) begin
               if (!r_last) begin
                  w_cur_line_nxt = w_adv_line;
                  w_addr_nxt     = w_adv_addr;
                  w_lo_nxt       = '0;
                  w_hi_nxt       = (w_adv_line == r_end_line) ? r_hi_slot : SLOT_MAX;
                  w_last_nxt     = (w_adv_line == r_end_line);
               end else if (!w_empty) begin
                  w_load = 1'b1;
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_valid_nxt = 1'b0;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b0;
         end
      endcase

      // Loading from the FIFO head covers both the idle start and back-to-back.
      if (w_load) begin
         w_state_nxt    = ST_ISSUE;
         w_valid_nxt    = 1'b1;
         w_cur_line_nxt = w_head_line;
         w_end_line_nxt = w_head_end;
         w_hi_slot_nxt  = w_head_last_edge[EDGE_SLOT_WIDTH-1:0];
         w_addr_nxt     = w_head_addr;
         w_vid_nxt      = w_head_id;
         w_lo_nxt       = w_head_lo[EDGE_SLOT_WIDTH-1:0];
         w_hi_nxt       = (w_head_line == w_head_end) ? w_head_last_edge[EDGE_SLOT_WIDTH-1:0] : SLOT_MAX;
         w_last_nxt     = (w_head_line == w_head_end);
      end
   end

   assign w_pop            = w_load;
   assign front_stall      = r_stall;
   assign err_sticky       = r_err;
   assign rd.edge_rd_addr  = r_addr;
   assign rd.edge_rd_v_id  = r_vid;
   assign rd.edge_rd_lo    = r_lo;
   assign rd.edge_rd_hi    = r_hi;
   assign rd.edge_rd_last  = r_last;
   assign rd.edge_rd_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_edge_req_gen.sv
//------------------------------------------------------------------------------
// Module   : tb_edge_req_gen
// Brief    : Scoreboard bench for edge_req_gen with a URAM latency model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_edge_req_gen;
   import edge_req_gen_pkg::*;

   localparam int V_ID_WIDTH   = 16;
   localparam int V_OFF_DWIDTH = 32;
   localparam int HBM_AWIDTH   = 32;
   localparam int URAM_DELAY   = 3;
   localparam int FIFO_DEPTH   = 16;
   localparam int STALL_TH     = FIFO_DEPTH - URAM_DELAY - 1;

   typedef struct packed {
      logic [31:0] addr;
      logic [15:0] vid;
      logic [3:0]  lo;
      logic [3:0]  hi;
      logic        last;
   } req_t;

   typedef struct {
      int          due;
      logic [31:0] lo;
      logic [31:0] ro;
   } uram_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] front_active_v_id = '0;
   logic        front_active_v_valid = 1'b0;
   logic [31:0] uram_loffset = '0;
   logic [31:0] uram_roffset = '0;
   logic        uram_dvalid = 1'b0;
   logic [31:0] edge_base_addr = 32'h0000_1000;
   logic        front_stall;
   logic        err_sticky;

   req_t  exp_q[$];
   uram_t uram_q[$];
   int    hs_cyc[$];
   int    checks = 0;
   int    failures = 0;
   int    cyc = 0;
   int    rdy_mode = 1;
   bit    exp_err = 1'b0;
   bit    ovf_mode = 1'b0;
   int    ovf_accept = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   edge_req_gen_if #(.V_ID_WIDTH(V_ID_WIDTH), .HBM_AWIDTH(HBM_AWIDTH)) rd_if ();

   edge_req_gen #(
      .V_ID_WIDTH   (V_ID_WIDTH),
      .V_OFF_DWIDTH (V_OFF_DWIDTH),
      .HBM_AWIDTH   (HBM_AWIDTH),
      .URAM_DELAY   (URAM_DELAY),
      .FIFO_DEPTH   (FIFO_DEPTH)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .front_active_v_id    (front_active_v_id),
      .front_active_v_valid (front_active_v_valid),
      .uram_loffset         (uram_loffset),
      .uram_roffset         (uram_roffset),
      .uram_dvalid          (uram_dvalid),
      .edge_base_addr       (edge_base_addr),
      .front_stall          (front_stall),
      .err_sticky           (err_sticky),
      .rd                   (rd_if)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic req_t cur_bus();
      return {rd_if.edge_rd_addr, rd_if.edge_rd_v_id, rd_if.edge_rd_lo,
              rd_if.edge_rd_hi, rd_if.edge_rd_last};
   endfunction

   // Reference: walk the edges one by one and emit one request per touched line.
   task automatic expect_vertex(input logic [15:0] id, input int lo, input int ro);
      req_t r;
      int   line;
      if (ro < lo) begin
         exp_err = 1'b1;
         return;
      end
      if (ro == lo) return;
      if (ovf_mode) begin
         if (ovf_accept >= FIFO_DEPTH + 1) begin
            exp_err = 1'b1;
            return;
         end
         ovf_accept++;
      end
      line = -1;
      r    = '0;
      for (int e = lo; e < ro; e++) begin
         if (e / EDGES_PER_LINE != line) begin
            if (line >= 0) exp_q.push_back(r);
            line   = e / EDGES_PER_LINE;
            r.addr = edge_base_addr + 32'(line * LINE_BYTES);
            r.vid  = id;
            r.lo   = 4'(e % EDGES_PER_LINE);
            r.last = 1'b0;
         end
         r.hi = 4'(e % EDGES_PER_LINE);
      end
      r.last = 1'b1;
      exp_q.push_back(r);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic issue(input logic [15:0] id, input int lo, input int ro, input bit obey);
      int w = 0;
      while (obey && front_stall && w < 1000) begin
         tick(1);
         w++;
      end
      if (w >= 1000) begin
         $display("FAIL stall_timeout: front_stall stuck at 1 for %0d cycles", w);
         $fatal(1);
      end
      front_active_v_valid = 1'b1;
      front_active_v_id    = id;
      uram_q.push_back('{cyc + URAM_DELAY, 32'(lo), 32'(ro)});
      expect_vertex(id, lo, ro);
      tick(1);
      front_active_v_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int w = 0;
      while (exp_q.size() != 0 && w < 3000) begin
         tick(1);
         w++;
      end
      tick(URAM_DELAY + 4);
      check(name, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic wait_hs(input int n);
      int w = 0;
      while (hs_cyc.size() < n && w < 500) begin
         tick(1);
         w++;
      end
      check("wait_handshakes", 64'(hs_cyc.size() >= n), 64'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      front_active_v_valid = 1'b0;
      tick(2);
      exp_q.delete();
      uram_q.delete();
      hs_cyc.delete();
      exp_err = 1'b0;
      rst = 1'b0;
   endtask

   // URAM read model: offsets appear URAM_DELAY cycles after the read request.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         uram_dvalid = 1'b0;
         if (uram_q.size() > 0 && uram_q[0].due == cyc) begin
            uram_loffset = uram_q[0].lo;
            uram_roffset = uram_q[0].ro;
            uram_dvalid  = 1'b1;
            void'(uram_q.pop_front());
         end
      end
   end

   initial begin
      rd_if.edge_rd_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       rd_if.edge_rd_ready = 1'b0;
            1:       rd_if.edge_rd_ready = 1'b1;
            default: rd_if.edge_rd_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Monitor: pops the scoreboard on every handshake, checks hold while stalled.
   initial begin
      req_t held;
      req_t e;
      bit   held_v = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            held_v = 1'b0;
            continue;
         end
         if (held_v) begin
            check("hold_valid", 64'(rd_if.edge_rd_valid), 64'd1);
            check("hold_bus", 64'(cur_bus()), 64'(held));
            held_v = 1'b0;
         end
         if (rd_if.edge_rd_valid === 1'b1) begin
            if (rd_if.edge_rd_ready === 1'b1) begin
               hs_cyc.push_back(cyc);
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_req: got 0x%0h expected none (cycle %0d)", cur_bus(), cyc);
               end else begin
                  e = exp_q.pop_front();
                  check("req", 64'(cur_bus()), 64'(e));
               end
            end else begin
               held   = cur_bus();
               held_v = 1'b1;
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      int n;
      tick(3);
      check("rst_valid", 64'(rd_if.edge_rd_valid), 64'd0);
      check("rst_addr",  64'(rd_if.edge_rd_addr),  64'd0);
      check("rst_vid",   64'(rd_if.edge_rd_v_id),  64'd0);
      check("rst_lo",    64'(rd_if.edge_rd_lo),    64'd0);
      check("rst_hi",    64'(rd_if.edge_rd_hi),    64'd0);
      check("rst_last",  64'(rd_if.edge_rd_last),  64'd0);
      check("rst_stall", 64'(front_stall),         64'd0);
      check("rst_err",   64'(err_sticky),          64'd0);
      rst = 1'b0;
      tick(1);

      rdy_mode = 1;
      issue(16'd5, 3, 7, 1'b1);
      drain("drain_single");

      hs_cyc.delete();
      issue(16'd6, 14, 35, 1'b1);
      issue(16'd7, 32, 40, 1'b1);
      drain("drain_b2b");
      check("b2b_count", 64'(hs_cyc.size()), 64'd4);
      if (hs_cyc.size() == 4) begin
         check("b2b_no_bubble", 64'(hs_cyc[3] - hs_cyc[0]), 64'd3);
      end

      hs_cyc.delete();
      issue(16'd9, 0, 100, 1'b1);
      wait_hs(2);
      rdy_mode = 0;
      tick(5);
      rdy_mode = 1;
      drain("drain_backpressure");

      issue(16'd10, 20, 20, 1'b1);
      tick(URAM_DELAY + 4);
      check("err_eq_offsets", 64'(err_sticky), 64'd0);
      issue(16'd11, 30, 25, 1'b1);
      tick(URAM_DELAY + 4);
      check("err_ro_lt_lo", 64'(err_sticky), 64'd1);
      drain("drain_special");

      rdy_mode = 2;
      for (int k = 0; k < 60; k++) begin
         int lo;
         int ro;
         lo = $urandom_range(5, 2000);
         if ($urandom_range(0, 9) == 0) ro = lo - $urandom_range(1, 5);
         else                           ro = lo + $urandom_range(0, 40);
         issue(16'($urandom), lo, ro, 1'b1);
         tick($urandom_range(0, 2));
      end
      drain("drain_random");
      check("err_random", 64'(err_sticky), 64'(exp_err));

      rdy_mode = 2;
      do_reset();
      edge_base_addr = 32'hFFFF_FF00;
      tick(1);
      check("err_after_reset", 64'(err_sticky), 64'd0);
      rdy_mode   = 0;
      tick(1);
      ovf_mode   = 1'b1;
      ovf_accept = 0;
      n = 0;
      while (!front_stall && n < 100) begin
         issue(16'(100 + n), n * 16 + 2, n * 16 + 9, 1'b0);
         n++;
      end
      // Stall is visible after the threshold fills plus the URAM latency and register lag.
      check("stall_issue_count", 64'(n), 64'(STALL_TH + URAM_DELAY + 2));
      tick(URAM_DELAY + 3);
      check("no_overflow_err", 64'(err_sticky), 64'd0);
      check("stall_held", 64'(front_stall), 64'd1);
      issue(16'd200, 7, 9, 1'b0);
      issue(16'd201, 7, 9, 1'b0);
      tick(URAM_DELAY + 3);
      check("overflow_err", 64'(err_sticky), 64'(exp_err));
      rdy_mode = 2;
      drain("drain_overflow");
      ovf_mode = 1'b0;
      check("stall_released", 64'(front_stall), 64'd0);

      rdy_mode = 1;
      hs_cyc.delete();
      issue(16'h55, 0, 200, 1'b1);
      wait_hs(3);
      rst = 1'b1;
      tick(1);
      check("rst_mid_valid", 64'(rd_if.edge_rd_valid), 64'd0);
      exp_q.delete();
      uram_q.delete();
      exp_err = 1'b0;
      tick(1);
      rst = 1'b0;
      tick(10);
      check("post_rst_valid", 64'(rd_if.edge_rd_valid), 64'd0);
      check("post_rst_err", 64'(err_sticky), 64'd0);
      issue(16'd1, 5, 6, 1'b1);
      drain("drain_after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/edge_req_gen.md
Name: edge_req_gen

Overview:
Per-core stage directly downstream of the offset URAM. It takes each active vertex's left/right edge offsets {loffset, roffset} and expands them into a stream of cacheline-aligned HBM edge-list read requests. Each request carries the intra-line valid-edge window. One instance per core; the top level instantiates CORE_NUM copies. A small FIFO absorbs the non-stallable URAM read pipeline, and the block back-pressures the active-vertex issuer upstream.

Parameters:
V_ID_WIDTH, `V_ID_WIDTH, vertex id width
V_OFF_DWIDTH, `V_OFF_DWIDTH (32), offset data width, in edges
HBM_AWIDTH, `HBM_AWIDTH, HBM byte address width
URAM_DELAY, `URAM_DELAY, cycles from front_active_v_valid to uram_dvalid
EDGE_BYTES, 4, bytes per edge entry
LINE_BYTES, 64, bytes per edge read request; EDGES_PER_LINE = LINE_BYTES/EDGE_BYTES = 16
FIFO_DEPTH, 16, offset FIFO entries; must be > URAM_DELAY + 2

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
front_active_v_id  in  V_ID_WIDTH  vertex id, presented in the same cycle as the URAM read request
front_active_v_valid  in  1  URAM read request issued this cycle
uram_loffset  in  V_OFF_DWIDTH  first edge index, inclusive
uram_roffset  in  V_OFF_DWIDTH  end edge index, exclusive
uram_dvalid  in  1  offsets valid; arrives URAM_DELAY cycles after front_active_v_valid
edge_base_addr  in  HBM_AWIDTH  edge array base address; LINE_BYTES aligned; static while rst=0
edge_rd_ready  in  1  downstream accepts a request
front_stall  out  1  upstream must not assert front_active_v_valid
edge_rd_addr  out  HBM_AWIDTH  line address
edge_rd_v_id  out  V_ID_WIDTH  owning vertex
edge_rd_lo  out  4  first valid edge slot in the line
edge_rd_hi  out  4  last valid edge slot in the line, inclusive
edge_rd_last  out  1  final line of this vertex
edge_rd_valid  out  1  request valid
err_sticky  out  1  FIFO overflow or roffset<loffset seen since reset

Behaviour:
- Reset: all outputs are 0, the FIFO is emptied, the FSM goes to IDLE and the id delay line is cleared. Reset mid-burst abandons the current vertex with no further requests.
- ID alignment: front_active_v_id passes through a URAM_DELAY-deep shift register so that it pairs with uram_dvalid.
- Push: on uram_dvalid, {id, loffset, roffset} is written to the FIFO.
  - roffset==loffset: entry is dropped silently, no request.
  - roffset<loffset: entry is dropped and err_sticky is set.
  - Push while the FIFO is full: entry is dropped and err_sticky is set.
- front_stall is registered and equals (count >= FIFO_DEPTH - URAM_DELAY - 1). This covers every in-flight URAM read.
- FSM has two states, IDLE and ISSUE.
  - IDLE & FIFO not empty: pop. cur_line = loffset>>4, end_line = (roffset-1)>>4, lo_slot = loffset[3:0], hi_slot = (roffset-1)[3:0]. Go to ISSUE. The first edge_rd_valid appears 1 cycle after the pop.
  - ISSUE: edge_rd_valid = 1.
    - edge_rd_addr = edge_base_addr + (cur_line << 6), truncated to HBM_AWIDTH.
    - edge_rd_lo = (first line) ? lo_slot : 0.
    - edge_rd_hi = (cur_line == end_line) ? hi_slot : 15.
    - edge_rd_last = (cur_line == end_line).
  - ISSUE handshake (valid & ready): if not last, cur_line++. If last and the FIFO is not empty, pop the next entry in the same cycle (back-to-back, no bubble). If last and the FIFO is empty, go to IDLE.
- Valid-ready rules:
  - Outputs hold stable while valid & !ready.
  - Valid never drops without a handshake, except on reset.
- Simultaneous push and pop: both take effect and count is unchanged. A push into an empty FIFO can be popped no earlier than the next cycle.
- Throughput: 1 line per cycle when ready is held high.

Decomposition:
- Shared header accelerator.vh gains EDGE_BYTES, LINE_BYTES and EDGE_SLOT_WIDTH (4). FIFO_DEPTH stays local.
- Sub-module edge_req_fifo: synchronous FIFO, first-word registered, with a count output. It is reused by later edge stages.

Test Plan:
- Single vertex, id=5, lo=3, ro=7, base=0x1000, ready=1 -> one request: addr 0x1000, lo 3, hi 6, last 1.
- Vertex spanning lines, lo=14, ro=35 -> three requests: addr base+0x00 (lo 14, hi 15), base+0x40 (0..15), base+0x80 (0..2, last=1).
- Back-to-back vertices queued with ready=1 -> no idle cycle between the first vertex's last line and the second vertex's first line.
- Backpressure: ready=0 for 5 cycles mid-burst -> addr/lo/hi/last held constant; issue resumes exactly where it stopped.
- Special entries: ro==lo -> no request, err_sticky stays 0; ro<lo -> no request, err_sticky = 1.
- FIFO pressure with ready=0: front_stall asserts at count = FIFO_DEPTH - URAM_DELAY - 1; with upstream obeying it, no overflow occurs. Forcing one extra push when full -> entry dropped and err_sticky = 1.
- Reset asserted mid-burst -> edge_rd_valid = 0 the next cycle, FIFO empty, no stale request after reset is released.
